mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end that sits between a simple request port and a
// single-outstanding word-wide memory. Handles byte lane steering for
// stores, lane extraction with sign/zero extension for loads, alignment
// errors and a bounded wait for the memory response.
module mem_access_unit #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WIDTH/8-1:0]    mem_byte_enable,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_resp,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int LANES  = WIDTH / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    // Last ACCESS cycle index that may still wait; the timeout fires on it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic                r_size;
    logic                r_signed;
    logic [LANE_W-1:0]   r_lane;

    logic [LANE_W-1:0]   w_lane;
    logic                w_misaligned;
    logic [LANES-1:0]    w_be_byte;
    logic [WIDTH-1:0]    w_wdata_byte;
    logic [7:0]          w_rbyte;
    logic [WIDTH-1:0]    w_load_data;

    assign w_lane       = req_addr[LANE_W-1:0];
    assign w_misaligned = req_size && (w_lane != '0);
    assign w_be_byte    = LANES'(1) << w_lane;
    assign w_wdata_byte = {LANES{req_wdata[7:0]}};
    assign w_load_data  = r_size ? mem_rdata
                                 : {{(WIDTH-8){r_signed & w_rbyte[7]}}, w_rbyte};

    // Pick the byte lane of the returning read data named by the captured address.
    always_comb begin
        w_rbyte = mem_rdata[7:0];
        for (int i = 0; i < LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_rbyte = mem_rdata[i*8 +: 8];
            end
        end
    end

    // Request FSM: accept, drive the memory strobes, wait/timeout, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_write         <= 1'b0;
            r_size          <= 1'b0;
            r_signed        <= 1'b0;
            r_lane          <= '0;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_error      <= 1'b0;
            resp_rdata      <= '0;
            mem_address     <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_wdata       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_lane      <= w_lane;
                        r_cnt       <= '0;
                        mem_address <= {req_addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
                        if (w_misaligned) begin
                            // Never touches memory; report the error straight away.
                            r_state    <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            r_state         <= S_ACCESS;
                            mem_read        <= !req_write;
                            mem_write       <= req_write;
                            mem_byte_enable <= (req_write && !req_size) ? w_be_byte : '1;
                            mem_wdata       <= req_size ? req_wdata : w_wdata_byte;
                        end
                    end
                end
                S_ACCESS: begin
                    // A response on the final allowed cycle still wins over the timeout.
                    if (mem_resp) begin
                        r_state    <= S_DONE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= r_write ? '0 : w_load_data;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_state    <= S_DONE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (WIDTH=16, TIMEOUT=4): a stimulus
// process issues requests, a memory responder answers them with a planned
// delay, and a monitor compares each response against a behavioural model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_write, req_size, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [15:0] resp_rdata;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [1:0]  mem_byte_enable;

    typedef struct {
        bit          wr;
        bit          sz;
        bit          sg;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;  // ACCESS cycles without mem_resp before responding
    } req_t;

    typedef struct {
        bit          err;
        logic [15:0] rdata;
        int          lat;    // clock edges from acceptance to the edge entering the response
        int          acc;
    } exp_t;

    req_t plan_q[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mem_access_unit #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(bit wr, bit sz, bit sg, logic [15:0] addr,
                                logic [15:0] wdata, logic [15:0] rdata, int delay);
        req_t r;
        r.wr = wr; r.sz = sz; r.sg = sg; r.addr = addr;
        r.wdata = wdata; r.rdata = rdata; r.delay = delay;
        return r;
    endfunction

    // Behavioural model: outcome of one request from the unit's rules.
    function automatic exp_t model(req_t r);
        exp_t e;
        int   lane;
        int   bv;
        lane    = r.addr % 2;
        e.err   = 1'b0;
        e.rdata = 16'd0;
        e.acc   = 0;
        if (r.sz && lane != 0) begin
            e.err = 1'b1;
            e.lat = 0;
            return e;
        end
        if (r.delay + 1 > TO) begin
            e.err = 1'b1;
            e.lat = TO;
            return e;
        end
        e.lat = r.delay + 1;
        if (!r.wr) begin
            if (r.sz) begin
                e.rdata = r.rdata;
            end else begin
                bv = (int'(r.rdata) >> (8 * lane)) % 256;
                if (r.sg && bv >= 128) bv = bv - 256;
                e.rdata = 16'(bv);
            end
        end
        return e;
    endfunction

    task automatic issue(input req_t r, input bit expect_resp);
        int   guard;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = r.wr;
        req_size   = r.sz;
        req_signed = r.sg;
        req_addr   = r.addr;
        req_wdata  = r.wdata;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got req_ready=0 expected 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (expect_resp) begin
            e     = model(r);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        if (!(r.sz && r.addr[0])) plan_q.push_back(r);
        // Disturb every request input after acceptance.
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 1'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 16'($urandom);
        req_wdata  = 16'($urandom);
    endtask

    // Memory responder: checks the memory-side drive and answers per plan.
    initial begin : responder
        req_t p;
        bit   exit_exp;
        int   guard;
        mem_resp  = 1'b0;
        mem_rdata = 16'd0;
        forever begin
            @(negedge clk);
            if (rst || !(mem_read || mem_write)) begin
                // Stray responses outside ACCESS must be ignored.
                mem_resp  = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
                continue;
            end
            if (plan_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unplanned_access: got mem_read=%0b mem_write=%0b expected none", mem_read, mem_write);
                mem_resp = 1'b0;
                guard = 0;
                while ((mem_read || mem_write) && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
                continue;
            end
            p = plan_q.pop_front();
            chk("mem_both", 32'(mem_read & mem_write), 32'd0);
            chk("mem_write", 32'(mem_write), 32'(p.wr));
            chk("mem_read", 32'(mem_read), 32'(!p.wr));
            chk("mem_address", 32'(mem_address), 32'(p.addr & 16'hFFFE));
            chk("mem_byte_enable", 32'(mem_byte_enable),
                (p.wr && !p.sz) ? (32'd1 << p.addr[0]) : 32'd3);
            if (p.wr) chk("mem_wdata", 32'(mem_wdata),
                          p.sz ? 32'(p.wdata) : 32'(p.wdata % 256) * 32'd257);
            for (int c = 1; c <= TO; c++) begin
                mem_resp  = (c == p.delay + 1);
                mem_rdata = mem_resp ? p.rdata : 16'($urandom);
                exit_exp  = mem_resp || (c == TO);
                @(negedge clk);
                mem_resp = 1'b0;
                if (rst) break;
                chk("strobe_exit", 32'(!(mem_read || mem_write)), 32'(exit_exp));
                if (exit_exp || !(mem_read || mem_write)) break;
                chk("mem_addr_hold", 32'(mem_address), 32'(p.addr & 16'hFFFE));
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is presented.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_error", 32'(resp_error), 32'(mon_e.err));
                chk("resp_rdata", 32'(resp_rdata), 32'(mon_e.rdata));
                chk("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                chk("ready_in_done", 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        req_t r;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 16'd0;
        req_wdata  = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_be", 32'(mem_byte_enable), 32'd0);
        rst = 1'b0;

        // Directed cases
        issue(mk(0, 0, 1, 16'h1001, 16'h0000, 16'h80FF, 1), 1'b1);   // signed byte load -> FF80
        issue(mk(1, 0, 0, 16'h2000, 16'h00AB, 16'h0000, 2), 1'b1);   // byte store lane 0
        issue(mk(0, 1, 0, 16'h0003, 16'h0000, 16'h1234, 0), 1'b1);   // misaligned word load
        issue(mk(0, 1, 0, 16'h0010, 16'h0000, 16'h5555, 99), 1'b1);  // no mem_resp -> timeout
        issue(mk(0, 1, 0, 16'h0012, 16'h0000, 16'hBEEF, 3), 1'b1);   // resp on the last cycle
        issue(mk(0, 0, 0, 16'h0011, 16'h0000, 16'h80FF, 0), 1'b1);   // unsigned byte load -> 0080
        issue(mk(1, 1, 0, 16'h4002, 16'hCAFE, 16'h0000, 0), 1'b1);   // word store
        issue(mk(1, 0, 0, 16'h3003, 16'h9A5C, 16'h0000, 1), 1'b1);   // byte store lane 1
        issue(mk(1, 1, 0, 16'h3005, 16'h1111, 16'h0000, 0), 1'b1);   // misaligned word store
        drain();

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = mk(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), $urandom_range(0, 5));
            issue(r, 1'b1);
        end
        drain();

        // Asynchronous reset during ACCESS: strobes drop at once, no response follows.
        issue(mk(0, 1, 0, 16'h0100, 16'h0000, 16'h7777, 100), 1'b0);
        @(negedge clk);
        #2;
        chk("mem_read_before_rst", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_read", 32'(mem_read), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd1);
        chk("async_rst_mem_address", 32'(mem_address), 32'd0);
        chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_resp_after_rst", 32'(exp_q.size()), 32'd0);

        // Unit works normally after reset.
        issue(mk(0, 0, 1, 16'h0201, 16'h0000, 16'h7F01, 0), 1'b1);
        issue(mk(0, 1, 0, 16'h0202, 16'h0000, 16'hA5A5, 2), 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
